// File: rtl/forward_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// forward_scoreboard_pkg
// Shared pipeline definitions for the forwarding / load-use hazard unit:
//   - DEF_REG_ADDR_W : default register address width
//   - fwd_sel_e      : forwarding select encoding (register file, MEM, WB)
//   - slot_t         : one shadow-pipeline slot {valid, rd, regwrite, memread}
//   - slot_writes()  : "this slot produces the value this operand reads"
// ----------------------------------------------------------------------------
package forward_scoreboard_pkg;

    localparam int unsigned DEF_REG_ADDR_W = 5;

    // Select k means "forward from shadow slot k"; 0 reads the register file.
    typedef enum int unsigned {
        SEL_RF  = 0,
        SEL_MEM = 1,
        SEL_WB  = 2
    } fwd_sel_e;

    // The slot record fixes rd at the package width; a core with a different
    // register address width changes DEF_REG_ADDR_W here.
    typedef struct packed {
        logic                      valid;
        logic [DEF_REG_ADDR_W-1:0] rd;
        logic                      regwrite;
        logic                      memread;
    } slot_t;

    // x0 is never a producer, so a reader of x0 never matches anything.
    function automatic logic slot_writes(input slot_t                     s,
                                         input logic [DEF_REG_ADDR_W-1:0] rs,
                                         input logic                      used);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == rs) && used;
    endfunction

endpackage

// File: rtl/forward_scoreboard_if.sv
// ----------------------------------------------------------------------------
// forward_scoreboard_if
// Bundle between the core's ID/EX control and the forwarding scoreboard.
//   hold_i, flush_i            : global freeze / kill instruction in ID
//   id_valid_i, id_rs_i,
//   id_rs_used_i, id_rd_i,
//   id_regwrite_i, id_memread_i: decoded ID instruction
//   stall_o                    : load-use stall towards ID
//   fwd_sel_o                  : per-operand EX forwarding select
//   stall_cnt_o                : saturating stall-cycle counter
// master = core side, slave = scoreboard side.
// ----------------------------------------------------------------------------
interface forward_scoreboard_if
    import forward_scoreboard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned SEL_W      = 2
);
    logic                          hold_i;
    logic                          flush_i;
    logic                          id_valid_i;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_i;
    logic [NUM_SRC-1:0]            id_rs_used_i;
    logic [REG_ADDR_W-1:0]         id_rd_i;
    logic                          id_regwrite_i;
    logic                          id_memread_i;
    logic                          stall_o;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o;
    logic [15:0]                   stall_cnt_o;

    modport master (
        output hold_i, flush_i, id_valid_i, id_rs_i, id_rs_used_i, id_rd_i,
               id_regwrite_i, id_memread_i,
        input  stall_o, fwd_sel_o, stall_cnt_o
    );

    modport slave (
        input  hold_i, flush_i, id_valid_i, id_rs_i, id_rs_used_i, id_rd_i,
               id_regwrite_i, id_memread_i,
        output stall_o, fwd_sel_o, stall_cnt_o
    );

endinterface

// File: rtl/forward_scoreboard_fwd_match.sv
// ----------------------------------------------------------------------------
// forward_scoreboard_fwd_match
// Forwarding select for one EX operand.
//   rs_i, used_i : operand address and "operand is read"
//   slots_i      : shadow slots 1..FWD_DEPTH (slot 1 = MEM, youngest)
//   sel_o        : 0 = register file, k = forward from slot k
// The youngest matching slot wins. A load that has not yet produced data
// (slot index <= LOAD_LAT) is skipped so an older producer can still win.
// ----------------------------------------------------------------------------
module forward_scoreboard_fwd_match
    import forward_scoreboard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned FWD_DEPTH  = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  used_i,
    input  slot_t [FWD_DEPTH:1]   slots_i,
    output logic [SEL_W-1:0]      sel_o
);

    // Walk oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        sel_o = SEL_W'(SEL_RF);
        for (int k = int'(FWD_DEPTH); k >= int'(SEL_MEM); k--) begin
            if (slot_writes(slots_i[k], rs_i, used_i) &&
                !(slots_i[k].memread && (k <= int'(LOAD_LAT)))) begin
                sel_o = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// ----------------------------------------------------------------------------
// forward_scoreboard
// Forwarding and load-use hazard unit with its own shadow pipeline of
// in-flight destinations (slot 0 = EX, slot k = k stages after EX).
//   clk_i : clock, rising edge
//   rst_i : asynchronous, active-low reset
//   bus   : forward_scoreboard_if.slave (ID instruction in, stall/selects out)
// stall_o is combinational from the ID inputs and the registered slots;
// fwd_sel_o is combinational from the EX operands and slots 1..FWD_DEPTH.
// ----------------------------------------------------------------------------
module forward_scoreboard
    import forward_scoreboard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_DEPTH  = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input logic                 clk_i,
    input logic                 rst_i,
    forward_scoreboard_if.slave bus
);

    slot_t [FWD_DEPTH:0]           slot_q, slot_d;
    logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs_q, ex_rs_d;
    logic [NUM_SRC-1:0]            ex_used_q, ex_used_d;
    logic [15:0]                   stall_cnt_q, stall_cnt_d;
    logic                          load_use;
    logic                          stall;
    logic                          issue;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;

    // Load-use: an ID operand depends on a load whose data is not yet
    // forwardable (still in slots 0..LOAD_LAT-1).
    always_comb begin
        load_use = 1'b0;
        for (int j = 0; j < int'(NUM_SRC); j++) begin
            for (int k = 0; k < int'(LOAD_LAT); k++) begin
                if (slot_q[k].memread &&
                    slot_writes(slot_q[k], bus.id_rs_i[j*REG_ADDR_W +: REG_ADDR_W],
                                bus.id_rs_used_i[j])) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    // Flush beats stall: the instruction is dead, so there is nothing to hold.
    assign stall = bus.id_valid_i && !bus.flush_i && load_use;
    assign issue = bus.id_valid_i && !bus.flush_i && !load_use;

    always_comb begin
        slot_d      = slot_q;
        ex_rs_d     = ex_rs_q;
        ex_used_d   = ex_used_q;
        stall_cnt_d = stall_cnt_q;
        if (!bus.hold_i) begin
            for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
                slot_d[k] = slot_q[k-1];
            end
            // Bubbles clear the operand-used bits so EX never selects for them.
            slot_d[0] = '0;
            ex_used_d = '0;
            if (issue) begin
                slot_d[0].valid    = 1'b1;
                slot_d[0].rd       = bus.id_rd_i;
                slot_d[0].regwrite = bus.id_regwrite_i;
                slot_d[0].memread  = bus.id_memread_i;
                ex_rs_d            = bus.id_rs_i;
                ex_used_d          = bus.id_rs_used_i;
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            slot_q      <= '0;
            ex_rs_q     <= '0;
            ex_used_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            ex_rs_q     <= ex_rs_d;
            ex_used_q   <= ex_used_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        forward_scoreboard_fwd_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .FWD_DEPTH  (FWD_DEPTH),
            .LOAD_LAT   (LOAD_LAT),
            .SEL_W      (SEL_W)
        ) u_match (
            .rs_i    (ex_rs_q[j*REG_ADDR_W +: REG_ADDR_W]),
            .used_i  (ex_used_q[j]),
            .slots_i (slot_q[FWD_DEPTH:1]),
            .sel_o   (fwd_sel[j*SEL_W +: SEL_W])
        );
    end

    assign bus.stall_o     = stall;
    assign bus.fwd_sel_o   = fwd_sel;
    assign bus.stall_cnt_o = stall_cnt_q;

endmodule
